dma_controller: RTL and testbench

DMA_CONTROLLER -- requirements
Module: dma_controller

---
 rtl/dma_controller.sv | 127 ++++++++++++
 tb/tb_dma_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dma_controller.sv
// dma_controller: device-to-memory DMA engine packing 4 words per line; define DMA_CYCLE_STEAL_EN for per-line bus release, else burst
module dma_controller #(
    parameter int WORD_SIZE     = 16,
    parameter int FETCH_SIZE    = 64,
    parameter int WRITE_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    input  logic [WORD_SIZE-1:0]  cmd_addr,
    input  logic [WORD_SIZE-1:0]  cmd_length,
    output logic                  cmd_ready,
    input  logic                  dev_valid,
    input  logic [WORD_SIZE-1:0]  dev_word,
    output logic                  dev_ready,
    output logic                  BR,
    input  logic                  BG,
    output logic                  d_writeM,
    output logic [WORD_SIZE-1:0]  d_addressM,
    output logic [FETCH_SIZE-1:0] d_dataM,
    output logic                  dma_end,
    output logic [WORD_SIZE-1:0]  words_done
);
    localparam int WCW = $clog2(WRITE_LATENCY) + 1;

    typedef enum logic [2:0] {IDLE, FILL, REQ, WRITE, WAIT, DONE} state_t;

    state_t                state, state_nx;
    logic [WORD_SIZE-1:0]  base, remaining;
    logic [FETCH_SIZE-1:0] line_buf;
    logic [1:0]            slot;
    logic [WCW-1:0]        wait_cnt;
    logic                  line_done, last_line, drive;
    logic [WORD_SIZE-1:0]  addr4, len4;

    assign addr4     = cmd_addr & ~WORD_SIZE'(3);
    assign len4      = cmd_length & ~WORD_SIZE'(3);
    assign last_line = remaining == WORD_SIZE'(4);
    assign line_done = (WRITE_LATENCY < 2) ? state == WRITE
                     : (state == WAIT && wait_cnt == WCW'(WRITE_LATENCY - 2));

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        if (cmd_valid) state_nx = (len4 == '0) ? DONE : FILL;
            FILL:        if (dev_valid && slot == 2'd3) state_nx = REQ;
            REQ:         if (BG) state_nx = WRITE;
            WRITE, WAIT: state_nx = line_done ? (last_line ? DONE : FILL) : WAIT;
            DONE:        state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

`ifdef DMA_CYCLE_STEAL_EN
    // bus is requested only while a line is being handed over
    always_comb begin
        cmd_ready = state == IDLE;
        dev_ready = state == FILL;
        d_writeM  = state == WRITE;
        dma_end   = state == DONE;
        drive     = state == WRITE || state == WAIT;
        BR        = state == REQ || state == WRITE || state == WAIT;
    end
`else
    logic burst;

    // burst flag: bus stays owned from the first grant request until DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) burst <= 1'b0;
        else          burst <= (state == REQ) ? 1'b1 : (state == IDLE || state == DONE) ? 1'b0 : burst;
    end

    // outputs decoded from state; FILL keeps the bus once burst has started
    always_comb begin
        cmd_ready = state == IDLE;
        dev_ready = state == FILL;
        d_writeM  = state == WRITE;
        dma_end   = state == DONE;
        drive     = state == WRITE || state == WAIT;
        BR        = state == REQ || state == WRITE || state == WAIT || (state == FILL && burst);
    end
`endif

    assign d_addressM = drive ? base + words_done : 'z;
    assign d_dataM    = drive ? line_buf : 'z;

    // command latch and per-line progress counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base       <= '0;
            remaining  <= '0;
            words_done <= '0;
        end else if (state == IDLE && cmd_valid) begin
            base       <= addr4;
            remaining  <= len4;
            words_done <= '0;
        end else if (line_done) begin
            words_done <= words_done + WORD_SIZE'(4);
            remaining  <= remaining - WORD_SIZE'(4);
        end
    end

    // line buffer fill: one device word per accepted beat, slot wraps after 4
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_buf <= '0;
            slot     <= '0;
        end else if (state == FILL && dev_valid) begin
            for (int i = 0; i < 4; i++)
                if (slot == 2'(i)) line_buf[i*WORD_SIZE +: WORD_SIZE] <= dev_word;
            slot <= slot + 2'd1;
        end
    end

    // write-latency counter, running only in WAIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wait_cnt <= '0;
        else          wait_cnt <= (state == WAIT) ? wait_cnt + WCW'(1) : '0;
    end
endmodule

// File: tb/tb_dma_controller.sv
// tb_dma_controller: randomized transfers checked cycle by cycle against a transfer-level model
module tb_dma_controller;
    localparam int WL = 4;
`ifdef DMA_CYCLE_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif
    localparam int P_FILL = 0, P_REQ = 1, P_WRITE = 2, P_WAIT = 3, P_DONE = 4, P_IDLE = 5;

    logic        clk = 1'b0;
    logic        reset_n, cmd_valid, dev_valid, BG;
    logic [15:0] cmd_addr, cmd_length, dev_word;
    logic        cmd_ready, dev_ready, BR, d_writeM, dma_end;
    logic [15:0] words_done;
    wire  [15:0] d_addressM;
    wire  [63:0] d_dataM;

    int vectors = 0, errors = 0;
    logic [15:0] words [64];

    dma_controller dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
        .cmd_length(cmd_length), .cmd_ready(cmd_ready), .dev_valid(dev_valid),
        .dev_word(dev_word), .dev_ready(dev_ready), .BR(BR), .BG(BG),
        .d_writeM(d_writeM), .d_addressM(d_addressM), .d_dataM(d_dataM),
        .dma_end(dma_end), .words_done(words_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fill_words(input bit fixed);
        for (int i = 0; i < 64; i++) words[i] = fixed ? 16'((i % 4 + 1) * 16'h1111) : 16'($urandom);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_br"}, BR, 0);
        chk({tag, "_writeM"}, d_writeM, 0);
        chk({tag, "_dma_end"}, dma_end, 0);
        chk({tag, "_dev_ready"}, dev_ready, 0);
        chk({tag, "_words_done"}, words_done, 0);
    endtask

    // one whole transfer; the model follows the transfer at line/word granularity
    task automatic run_xfer(input logic [15:0] addr, input logic [15:0] len, input int stall, input bit abort);
        logic [15:0] base, len4, exp_addr;
        int n, phase, k, line, wcnt, st;
        bit fin;
        base = addr & 16'hFFFC;
        len4 = len & 16'hFFFC;
        n = int'(len4) / 4;
        k = 0; line = 0; wcnt = 0; st = stall; fin = 0;
        exp_addr = base;
        @(negedge clk);
        chk("cmd_ready_start", cmd_ready, 1);
        cmd_valid = 1; cmd_addr = addr; cmd_length = len; dev_valid = 0; BG = 0;
        phase = (len4 == 0) ? P_DONE : P_FILL;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom); cmd_addr = 16'($urandom); cmd_length = 16'($urandom);
            dev_valid = 1'($urandom); dev_word = 16'($urandom); BG = 1'($urandom);
            if (phase != P_DONE) chk("dma_end_low", dma_end, 0);
            case (phase)
                P_FILL: begin
                    chk("fill_dev_ready", dev_ready, 1);
                    chk("fill_cmd_ready", cmd_ready, 0);
                    chk("fill_writeM", d_writeM, 0);
                    chk("fill_words_done", words_done, 16'(line * 4));
                    chk("fill_br", BR, STEAL ? 1'b0 : (line > 0));
                    dev_valid = $urandom_range(0, 3) != 0;
                    dev_word = words[line * 4 + k];
                    if (dev_valid) begin
                        k++;
                        if (k == 4) begin k = 0; phase = P_REQ; end
                    end
                end
                P_REQ: begin
                    chk("req_br", BR, 1);
                    chk("req_dev_ready", dev_ready, 0);
                    chk("req_writeM", d_writeM, 0);
                    if (st > 0) begin BG = 0; st--; end
                    if (BG) phase = P_WRITE;
                end
                P_WRITE: begin
                    exp_addr = base + 16'(line * 4);
                    chk("wr_strobe", d_writeM, 1);
                    chk("wr_br", BR, 1);
                    chk("wr_addr", d_addressM, exp_addr);
                    chk("wr_data", d_dataM, {words[line*4+3], words[line*4+2], words[line*4+1], words[line*4]});
                    wcnt = 0;
                    phase = P_WAIT;
                end
                P_WAIT: begin
                    chk("wait_strobe", d_writeM, 0);
                    chk("wait_br", BR, 1);
                    chk("wait_addr", d_addressM, exp_addr);
                    chk("wait_data", d_dataM, {words[line*4+3], words[line*4+2], words[line*4+1], words[line*4]});
                    if (abort && line == 1) begin
                        cmd_valid = 0;
                        reset_n = 0;
                        #1;
                        check_reset_state("abort");
                        @(negedge clk);
                        reset_n = 1;
                        repeat (5) begin
                            @(negedge clk);
                            chk("post_reset_no_write", d_writeM, 0);
                            chk("post_reset_idle", cmd_ready, 1);
                        end
                        fin = 1;
                    end else begin
                        wcnt++;
                        if (wcnt == WL - 1) begin
                            line++;
                            phase = (line == n) ? P_DONE : P_FILL;
                        end
                    end
                end
                P_DONE: begin
                    chk("done_pulse", dma_end, 1);
                    chk("done_br", BR, 0);
                    chk("done_writeM", d_writeM, 0);
                    chk("done_words", words_done, len4);
                    chk("done_lines", 32'(line), 32'(n));
                    phase = P_IDLE;
                end
                default: begin
                    cmd_valid = 0;
                    chk("idle_cmd_ready", cmd_ready, 1);
                    chk("idle_br", BR, 0);
                    fin = 1;
                end
            endcase
        end
        if (!fin) chk("timeout", 0, 1);
        cmd_valid = 0;
    endtask

    initial begin
        reset_n = 0; cmd_valid = 0; cmd_addr = 0; cmd_length = 0;
        dev_valid = 0; dev_word = 0; BG = 0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset_n = 1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_write", d_writeM, 0);
        end
        fill_words(1);
        run_xfer(16'h01F2, 16'd4, 0, 0);
        fill_words(0);
        run_xfer(16'h0100, 16'd12, 0, 0);
        run_xfer(16'h0040, 16'd0, 0, 0);
        run_xfer(16'h0200, 16'd3, 0, 0);
        run_xfer(16'h0300, 16'd8, 10, 0);
        run_xfer(16'hFFFC, 16'd8, 0, 0);
        run_xfer(16'h0400, 16'd16, 0, 1);
        run_xfer(16'h0500, 16'd8, 0, 0);
        for (int t = 0; t < 25; t++) begin
            fill_words(0);
            run_xfer(16'($urandom), 16'($urandom_range(0, 24)), $urandom_range(0, 4), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
